fifo28_ctrl: RTL and testbench

FIFO28_CTRL -- requirements
Module: fifo28_ctrl

---
 rtl/fifo28_ctrl.sv | 149 ++++++++++++++
 tb/tb_fifo28_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo28_ctrl.sv
// fifo28_ctrl
//   Flow controller for a DEPTH-stage, 48-bit delay line. The datapath itself
//   has no reset. A tag shift register travels alongside the data and marks
//   which stages hold real samples. The tags drive out_valid, the occupancy
//   count and the frame sequencing.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   frame_start  1-cycle pulse, opens a frame (honoured only in IDLE)
//   in_valid     upstream sample present
//   in_last      with in_valid: final sample of the frame
//   in_ready     sample accepted this cycle when in_valid is also high
//   out_ready    downstream accepts the delay-line output
//   out_valid    delay-line output stage holds a real sample
//   flush        synchronous abort back to IDLE
//   shift_en     advance every delay-line stage by one
//   occupancy    number of real samples in the delay line (0..DEPTH)
//   state_o      IDLE=0, FILL=1, RUN=2, DRAIN=3
//   frame_done   1-cycle pulse when a drain completes
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame open; wait for frame_start
// FILL  | accepting samples; the line is not yet full
// RUN   | line full; each accepted sample pushes one sample out
// DRAIN | last sample taken; shift bubbles in until every tag is clear

module fifo28_ctrl #(
    parameter int DEPTH = 28,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    input  logic             flush,
    output logic             shift_en,
    output logic [CNT_W-1:0] occupancy,
    output logic [1:0]       state_o,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

    state_t             state_q;
    state_t             state_d;
    logic [DEPTH-1:0]   tag_q;
    logic [CNT_W-1:0]   occ_q;
    logic [CNT_W-1:0]   occ_d;
    logic               pass;
    logic               accept;
    logic               tags_empty;

    assign out_valid  = tag_q[DEPTH-1];
    // The output stage may only move when it is empty or being consumed.
    assign pass       = !tag_q[DEPTH-1] || out_ready;
    assign tags_empty = (tag_q == '0);
    assign occupancy  = occ_q;
    assign state_o    = state_q;

    always_comb begin
        in_ready   = 1'b0;
        accept     = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        occ_d      = occ_q;
        state_d    = state_q;

        in_ready = ((state_q == S_FILL) || (state_q == S_RUN)) && pass && !flush;
        accept   = in_valid && in_ready;
        // In DRAIN each shift inserts a bubble; the insert bit equals accept.
        shift_en = accept || ((state_q == S_DRAIN) && pass && !flush);

        if (shift_en) begin
            if (accept && !tag_q[DEPTH-1] && (occ_q != OCC_FULL)) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (!accept && tag_q[DEPTH-1] && (occ_q != '0)) begin
                occ_d = occ_q - CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // in_last wins over reaching full.
                if (accept) begin
                    if (in_last) begin
                        state_d = S_DRAIN;
                    end else if (occ_d == OCC_FULL) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tags_empty) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            occ_d      = '0;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            occ_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            if (flush) begin
                tag_q <= '0;
            end else if (shift_en) begin
                tag_q <= {tag_q[DEPTH-2:0], accept};
            end
        end
    end

endmodule

// File: tb/tb_fifo28_ctrl.sv
// Bench for fifo28_ctrl. The reference model holds the delay line as an array
// of sample ids (0 = empty/bubble) and derives every output from it each cycle.
// A bench-side data line, clocked by the DUT's shift_en, checks sample order.
module tb_fifo28_ctrl;
    localparam int DEPTH = 28;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             frame_start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b1;
    logic             flush = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             shift_en;
    logic             frame_done;
    logic [CNT_W-1:0] occupancy;
    logic [1:0]       state_o;

    fifo28_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .flush(flush), .shift_en(shift_en),
        .occupancy(occupancy), .state_o(state_o), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int line [DEPTH];
    int nline[DEPTH];
    int mst = 0;
    int nst = 0;
    bit m_acc = 1'b0;
    int dl [DEPTH];
    int dl_in = 0;
    bit dl_sh = 1'b0;
    int sb[$];
    int cur_id = 0;
    int next_id = 1;
    int n_cmp_m = 0, n_err_m = 0, n_cmp_h = 0, n_err_h = 0;
    int xfer_cnt = 0, done_cnt = 0, drain_pop = 0, shift_cnt = 0;

    task automatic chk_m(input string name, input int act, input int exp);
        n_cmp_m++;
        if (act != exp) begin
            n_err_m++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_h(input string name, input int act, input int exp);
        n_cmp_h++;
        if (act != exp) begin
            n_err_h++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model evaluation and comparison, away from the active edge.
    always @(negedge clk) begin
        int  e_occ, n_occ, exp_id;
        bit  e_ov, p, e_ir, e_acc, e_sh, e_fd;
        if (!rst) begin
            chk_m("rst_state", state_o, 0);
            chk_m("rst_occupancy", occupancy, 0);
            chk_m("rst_out_valid", out_valid, 0);
            chk_m("rst_in_ready", in_ready, 0);
            chk_m("rst_shift_en", shift_en, 0);
            chk_m("rst_frame_done", frame_done, 0);
            for (int i = 0; i < DEPTH; i++) nline[i] = 0;
            nst   = 0;
            m_acc = 1'b0;
            dl_sh = 1'b0;
            dl_in = 0;
            sb.delete();
        end else begin
            e_occ = 0;
            for (int i = 0; i < DEPTH; i++) if (line[i] != 0) e_occ++;
            e_ov  = (line[DEPTH-1] != 0);
            p     = !e_ov || out_ready;
            e_ir  = ((mst == 1) || (mst == 2)) && p && !flush;
            e_acc = in_valid && e_ir;
            e_sh  = e_acc || ((mst == 3) && p && !flush);
            e_fd  = (mst == 3) && (e_occ == 0) && !flush;

            chk_m("state_o", state_o, mst);
            chk_m("occupancy", occupancy, e_occ);
            chk_m("out_valid", out_valid, e_ov);
            chk_m("in_ready", in_ready, e_ir);
            chk_m("shift_en", shift_en, e_sh);
            chk_m("frame_done", frame_done, e_fd);

            if (shift_en && out_valid) begin
                xfer_cnt++;
                if (state_o == 2'd3) drain_pop++;
                if (sb.size() == 0) begin
                    n_cmp_m++;
                    n_err_m++;
                    $display("FAIL data_order @%0t: got id %0d expected no transfer", $time, dl[DEPTH-1]);
                end else begin
                    exp_id = sb.pop_front();
                    chk_m("data_order", dl[DEPTH-1], exp_id);
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_id);
            if (shift_en) shift_cnt++;
            if (frame_done) done_cnt++;
            dl_sh = shift_en;
            dl_in = (in_valid && in_ready) ? cur_id : -1;
            m_acc = e_acc;

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) nline[i] = 0;
                nst = 0;
                sb.delete();
            end else begin
                if (e_sh) begin
                    nline[0] = e_acc ? cur_id : 0;
                    for (int i = 1; i < DEPTH; i++) nline[i] = line[i-1];
                end else begin
                    for (int i = 0; i < DEPTH; i++) nline[i] = line[i];
                end
                n_occ = 0;
                for (int i = 0; i < DEPTH; i++) if (nline[i] != 0) n_occ++;
                nst = mst;
                case (mst)
                    0: if (frame_start) nst = 1;
                    1: if (e_acc) begin
                           if (in_last) nst = 3;
                           else if (n_occ == DEPTH) nst = 2;
                       end
                    2: if (e_acc && in_last) nst = 3;
                    default: if (e_occ == 0) nst = 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= 0;
            mst <= 0;
        end else begin
            for (int i = 0; i < DEPTH; i++) line[i] <= nline[i];
            mst <= nst;
        end
        if (dl_sh) begin
            dl[0] <= dl_in;
            for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send1(input bit last);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_last  = last;
        cur_id   = next_id;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk);
            if (m_acc) got = 1'b1;
        end
        #1;
        if (!got) chk_h("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        next_id++;
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 120 && !hit; c++) begin
            tick();
            if (state_o == 2'd0) hit = 1'b1;
        end
        if (!hit) chk_h("idle_timeout", 0, 1);
    endtask

    initial begin
        int x0, d0, p0, s0;
        bit hit;

        repeat (2) @(posedge clk);
        #1;
        chk_h("reset_state", state_o, 0);
        chk_h("reset_occupancy", occupancy, 0);
        chk_h("reset_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        tick();
        chk_h("idle_in_ready", in_ready, 0);

        // Frame A: 40 samples, backpressure in RUN, last on 40th.
        x0 = xfer_cnt; d0 = done_cnt; p0 = drain_pop;
        pulse_start();
        chk_h("a_fill_entry", state_o, 1);
        for (int k = 1; k <= 40; k++) begin
            if (k == 31) begin
                in_valid  = 1'b1;
                cur_id    = next_id;
                out_ready = 1'b0;
                for (int b = 0; b < 5; b++) begin
                    #1;
                    chk_h("bp_in_ready", in_ready, 0);
                    chk_h("bp_shift_en", shift_en, 0);
                    chk_h("bp_out_valid", out_valid, 1);
                    tick();
                end
                out_ready = 1'b1;
            end
            send1(k == 40);
            if (k <= 28) begin
                chk_h("a_fill_state", state_o, (k < 28) ? 1 : 2);
                chk_h("a_fill_occ", occupancy, k);
                chk_h("a_fill_out_valid", out_valid, (k == 28) ? 1 : 0);
            end
            if (k == 40) begin
                chk_h("a_drain_state", state_o, 3);
                chk_h("a_drain_occ", occupancy, 28);
            end
        end
        wait_idle();
        chk_h("a_transfers", xfer_cnt - x0, 40);
        chk_h("a_drain_pops", drain_pop - p0, 28);
        chk_h("a_frame_done", done_cnt - d0, 1);
        chk_h("a_end_occ", occupancy, 0);

        // Frame B: short frame of 10.
        x0 = xfer_cnt; d0 = done_cnt;
        pulse_start();
        s0 = shift_cnt;
        for (int k = 1; k <= 10; k++) send1(k == 10);
        chk_h("b_state_drain", state_o, 3);
        chk_h("b_occ", occupancy, 10);
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            if (out_valid) hit = 1'b1;
            else tick();
        end
        chk_h("b_first_out_shifts", shift_cnt - s0, 28);
        wait_idle();
        chk_h("b_transfers", xfer_cnt - x0, 10);
        chk_h("b_frame_done", done_cnt - d0, 1);
        chk_h("b_end_occ", occupancy, 0);

        // Frame C: flush at occupancy 15 with a concurrent frame_start.
        d0 = done_cnt;
        pulse_start();
        for (int k = 1; k <= 15; k++) send1(1'b0);
        chk_h("c_occ15", occupancy, 15);
        chk_h("c_fill", state_o, 1);
        flush = 1'b1; frame_start = 1'b1; in_valid = 1'b1; cur_id = next_id;
        #1;
        chk_h("c_flush_in_ready", in_ready, 0);
        chk_h("c_flush_done", frame_done, 0);
        tick();
        flush = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
        chk_h("c_after_state", state_o, 0);
        chk_h("c_after_occ", occupancy, 0);
        chk_h("c_after_out_valid", out_valid, 0);
        tick();
        chk_h("c_stays_idle", state_o, 0);
        chk_h("c_no_done", done_cnt - d0, 0);

        // Frame D: asynchronous reset during DRAIN.
        pulse_start();
        for (int k = 1; k <= 5; k++) send1(k == 5);
        repeat (3) tick();
        chk_h("d_in_drain", state_o, 3);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_h("d_rst_state", state_o, 0);
        chk_h("d_rst_occ", occupancy, 0);
        chk_h("d_rst_out_valid", out_valid, 0);
        chk_h("d_rst_in_ready", in_ready, 0);
        chk_h("d_rst_shift_en", shift_en, 0);
        chk_h("d_rst_frame_done", frame_done, 0);
        repeat (2) tick();
        #2 rst = 1'b1;
        in_valid = 1'b1;
        cur_id = next_id;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_h("d_post_in_ready", in_ready, 0);
            chk_h("d_post_state", state_o, 0);
        end
        in_valid = 1'b0;
        pulse_start();
        chk_h("d_restart_state", state_o, 1);
        chk_h("d_restart_in_ready", in_ready, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp_m + n_cmp_h, n_err_m + n_err_h);
        $finish;
    end

endmodule
